// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: StoreMode
// encodings, FSM state encoding, and lane-mask / write-data alignment.
package dmem_pkg;

  localparam logic [1:0] SM_WORD = 2'b00;
  localparam logic [1:0] SM_HALF = 2'b01;
  localparam logic [1:0] SM_BYTE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } lane_t;

  // Byte-lane enables and lane-aligned write data for a store. Low address
  // bits that would make an access misaligned are simply ignored here:
  // words always cover all lanes, halfwords only look at addr_lo[1].
  function automatic lane_t lane_gen(input logic [1:0]  mode,
                                     input logic [1:0]  addr_lo,
                                     input logic [31:0] wdata);
    lane_t r;
    case (mode)
      SM_HALF: begin
        if (addr_lo[1]) begin
          r.mask = 4'b1100;
          r.data = {wdata[15:0], 16'h0000};
        end else begin
          r.mask = 4'b0011;
          r.data = {16'h0000, wdata[15:0]};
        end
      end
      SM_BYTE: begin
        r.mask = 4'b0001 << addr_lo;
        r.data = {24'h000000, wdata[7:0]} << {addr_lo, 3'b000};
      end
      default: begin
        r.mask = 4'b1111;
        r.data = wdata;
      end
    endcase
    return r;
  endfunction

  // Halfwords must be 2-byte aligned, words (modes 00 and 11) 4-byte aligned.
  function automatic logic is_misaligned(input logic [1:0] mode,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (mode)
      SM_HALF: bad = addr_lo[0];
      SM_BYTE: bad = 1'b0;
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH_WORDS x 32 RAM with per-byte write enables and a
// registered read port. The read returns the word as it stood before any
// write performed on the same edge.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           i_clk,
  input  logic                           i_en,
  input  logic [3:0]                     i_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Capture the old word and merge the enabled byte lanes on an access.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_rdata <= r_mem[i_addr];
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS load/store path. Accepts one request
// at a time, inserts WAIT_CYCLES wait states, commits lane-masked stores and
// returns the full aligned word for loads.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN adds the Err port and turns
// misaligned accesses into no-write, zero-data, Err-flagged responses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  input  logic [1:0]  StoreMode,
  output logic        Ready,
  output logic        RespValid,
  output logic [31:0] RdData
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        Err
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_count;
  logic          r_wr;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [1:0]    r_mode;

  logic          w_accept;
  logic          w_commit;
  logic          w_wr;
  logic [AW+1:0] w_addr;
  logic [31:0]   w_wdata;
  logic [1:0]    w_mode;
  lane_t         w_lane;
  logic [3:0]    w_we;
  logic [31:0]   w_rdata;
  logic          w_unused_addr;

  assign w_unused_addr = ^Addr[31:AW+2];

  assign Ready     = (r_state == S_IDLE) && Reset;
  assign RespValid = (r_state == S_RESP);
  assign w_accept  = Req && Ready;

  // With zero wait states the commit happens on the accept edge itself, so
  // the array is fed from the live inputs while idle and from the request
  // register otherwise.
  assign w_wr    = (r_state == S_IDLE) ? Wr            : r_wr;
  assign w_addr  = (r_state == S_IDLE) ? Addr[AW+1:0]  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? WrData        : r_wdata;
  assign w_mode  = (r_state == S_IDLE) ? StoreMode     : r_mode;
  assign w_lane  = lane_gen(w_mode, w_addr[1:0], w_wdata);

  // Next-state logic; w_commit marks the edge that enters RESP.
  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES > 0) begin
            w_next = S_WAIT;
          end else begin
            w_next   = S_RESP;
            w_commit = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (r_count == 4'd0) begin
          w_next   = S_RESP;
          w_commit = 1'b1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; reset aborts any request in flight.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request register and wait-state counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_count <= 4'd0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_mode  <= SM_WORD;
    end else if (w_accept) begin
      r_count <= WAIT_LOAD;
      r_wr    <= Wr;
      r_addr  <= Addr[AW+1:0];
      r_wdata <= WrData;
      r_mode  <= StoreMode;
    end else if ((r_state == S_WAIT) && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic w_req_bad;
  logic w_resp_bad;
  assign w_req_bad  = is_misaligned(w_mode, w_addr[1:0]);
  assign w_resp_bad = is_misaligned(r_mode, r_addr[1:0]);
  assign w_we   = (w_commit && w_wr && !w_req_bad) ? w_lane.mask : 4'b0000;
  assign RdData = (RespValid && !r_wr && !w_resp_bad) ? w_rdata : 32'd0;
  assign Err    = RespValid && w_resp_bad;
`else
  assign w_we   = (w_commit && w_wr) ? w_lane.mask : 4'b0000;
  assign RdData = (RespValid && !r_wr) ? w_rdata : 32'd0;
`endif

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .i_clk  (Clk),
    .i_en   (w_commit),
    .i_we   (w_we),
    .i_addr (w_addr[AW+1:2]),
    .i_wdata(w_lane.data),
    .o_rdata(w_rdata)
  );

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS core's load/store path. Accepts one request at a time from the datapath's memory stage (address, write data, read/write, StoreMode), inserts a programmable number of wait states, commits word/halfword/byte writes with lane masking, and returns the full aligned word for loads. The datapath performs load lane extraction and sign extension itself. This block replaces the zero-latency data memory when the core is moved to a stall-capable memory interface.

## Interface
- `DEPTH_WORDS`, 1024: storage depth in 32-bit words; power of two.
- `WAIT_CYCLES`, 1: wait states between accept and response; legal range 0..15.
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Req`  in  1  request valid.
- `Wr`  in  1  1 = store, 0 = load; sampled at accept.
- `Addr`  in  32  byte address; sampled at accept.
- `WrData`  in  32  store data, right-justified; sampled at accept.
- `StoreMode`  in  2  access size: 00 = word, 01 = halfword, 10 = byte, 11 = word.
- `Ready`  out  1  responder can accept; a request is accepted on an edge where `Req && Ready`.
- `RespValid`  out  1  one-cycle response strobe.
- `RdData`  out  32  aligned word for loads; 0 for stores.
- `Err`  out  1  misaligned access flag; present only with `DMEM_MISALIGN_TRAP_EN`.

## Operation
- **FSM states**
  - IDLE: `Ready=1`. Moves to WAIT on accept when `WAIT_CYCLES>0`, otherwise directly to RESP.
  - WAIT: a 4-bit counter loads `WAIT_CYCLES-1` on accept and decrements. Moves to RESP when the count reaches 0.
  - RESP: `RespValid=1` for exactly one cycle. Always returns to IDLE.
- **Request register:** `Wr`, `Addr`, `WrData` and `StoreMode` are latched at accept. Inputs are ignored outside IDLE. At most one request is outstanding.
- **Word index:** `Addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the depth.
- **Store lane rules** (little-endian):
  - Word: all 4 lanes written with `WrData`.
  - Halfword: `Addr[1]=0` writes `WrData[15:0]` into bits [15:0]; `Addr[1]=1` writes it into bits [31:16].
  - Byte: `WrData[7:0]` is written into lane `Addr[1:0]`, i.e. bits [8k+7:8k].
  - Unwritten lanes keep their contents.
- **Commit point:** the store is written and the load word is captured on the edge that enters RESP. `RdData` holds the word at the latched index as it stood before any same-request write.
- **Outputs in RESP:** `RdData` is the full word for loads and 0 for stores. Outside RESP, `RdData` is 0.
- **Misalignment:** a halfword access with `Addr[0]=1`, or a word access with `Addr[1:0]!=0`. Handling is set by Configuration.
- **StoreMode 11** behaves exactly as word.
- **Reset:** array contents are not reset.

## Timing
- **Reset values:** state IDLE, `Ready=1` once reset deasserts (0 while `Reset` is low), `RespValid=0`, `RdData=0`, `Err=0`, counter 0.
- **Latency:** accept on edge N → `RespValid` high during cycle N+1+`WAIT_CYCLES`. Example: `WAIT_CYCLES=1` gives a response 2 cycles after accept.
- **Throughput:** `Ready` returns high in the cycle after RESP. Back-to-back accepts are spaced `WAIT_CYCLES+2` cycles apart.
- **Ordering:** a load accepted after a store response sees the stored data. There is no bypass hazard because only one request is outstanding.
- **`Req` outside IDLE:** ignored. The requester must hold `Req` until it sees `Ready`.
- **Reset mid-operation:** reset in WAIT aborts the request with no write and no response. Reset in RESP forces `RespValid` low immediately; the write has already been committed.

## Configuration
- **`DMEM_MISALIGN_TRAP_EN` defined:**
  - `Err` port exists.
  - A misaligned access performs no write and returns `RdData=0`.
  - `Err=1` for the RESP cycle, with timing unchanged.
- **Undefined:**
  - No `Err` port.
  - Offending low address bits are ignored: word accesses use `Addr[1:0]=00`, halfword accesses use `Addr[1]` only.

## Structure
- **Package `dmem_pkg`:**
  - StoreMode encodings: `SM_WORD`, `SM_HALF`, `SM_BYTE`.
  - FSM state enum: `S_IDLE`, `S_WAIT`, `S_RESP`.
  - A function returning the 4-bit lane mask and shifted write data from `StoreMode` and `Addr[1:0]`.
- **Sub-module `dmem_array`:** synchronous single-port RAM, `DEPTH_WORDS`×32, with 4-bit byte-write enables and a registered read. The FSM, request register and wait counter live in the top level.

## Test plan
- **Word write then read:** `WAIT_CYCLES=1`, reset released.
  - Store word 0xDEADBEEF at 0x10 → `RespValid` 2 cycles after accept, `RdData=0`.
  - Load 0x10 → `RdData=0xDEADBEEF`.
- **Byte lanes:** word 0x00000000 at 0x20, then byte stores of 0xAA to 0x21 and 0x55 to 0x23 → load 0x20 returns 0x5500AA00.
- **Halfword lanes:** word 0x11223344 at 0x30, then halfword store 0xBEEF to 0x32 → load returns 0xBEEF3344.
- **Wait states:**
  - `WAIT_CYCLES=0` → response 1 cycle after accept; `Req` held continuously → accepts every 2 cycles.
  - `WAIT_CYCLES=15` → response 16 cycles after accept; `Ready` low throughout.
- **Reset abort:** `Reset` low during WAIT of a store of 0x12345678 to 0x40 → no `RespValid`; a later load of 0x40 returns the prior contents; `Ready=1` after release.
- **Misalign and wrap:**
  - Word store 0xCAFEF00D to 0x43 → with the macro: `Err=1`, memory unchanged; without: 0x40 now holds 0xCAFEF00D.
  - Load `DEPTH_WORDS*4+0x40` aliases 0x40.
